// File: rtl/elevator_pkg.sv
// Shared types and encodings for the elevator controller.
`default_nettype none

package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MOVE_UP    = 3'd1,
    ST_MOVE_DOWN  = 3'd2,
    ST_DOOR_OPEN  = 3'd3,
    ST_DOOR_CLOSE = 3'd4
  } state_t;

  localparam logic [1:0] ENGINE_STOP  = 2'b00;
  localparam logic [1:0] ENGINE_UP    = 2'b01;
  localparam logic [1:0] ENGINE_DOWN  = 2'b10;

  localparam logic [1:0] DOOR_CLOSED  = 2'b00;
  localparam logic [1:0] DOOR_OPEN    = 2'b01;
  localparam logic [1:0] DOOR_CLOSING = 2'b10;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_req_table.sv
// Sticky cabin/hall request registers plus per-floor scheduling summaries.
`default_nettype none

module elevator_req_table
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = 8,
  parameter int LW            = $clog2(BUTTONS_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] set_in,
  input  logic [BUTTONS_WIDTH-1:0] set_up,
  input  logic [BUTTONS_WIDTH-1:0] set_down,
  input  logic                     clr,
  input  logic [LW-1:0]            floor,
  input  logic                     dir,
  output logic                     any_above,
  output logic                     any_below,
  output logic                     any_at_floor,
  output logic                     hit_at_floor,
  output logic                     stop_here
);

  logic [BUTTONS_WIDTH-1:0] req_in, req_up, req_down, req_all;
  logic [BUTTONS_WIDTH-1:0] at_mask, above_mask, below_mask, clr_mask;

  always_comb begin
    at_mask    = '0;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      at_mask[i]    = (i == int'(floor));
      above_mask[i] = (i >  int'(floor));
      below_mask[i] = (i <  int'(floor));
    end
  end

  assign clr_mask = clr ? at_mask : '0;
  assign req_all  = req_in | req_up | req_down;

  // Clear wins over a same-cycle press so calls for an open floor are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_in   <= '0;
      req_up   <= '0;
      req_down <= '0;
    end else begin
      req_in   <= (req_in   | set_in)   & ~clr_mask;
      req_up   <= (req_up   | set_up)   & ~clr_mask;
      req_down <= (req_down | set_down) & ~clr_mask;
    end
  end

  assign any_above    = |(req_all & above_mask);
  assign any_below    = |(req_all & below_mask);
  assign any_at_floor = |(req_all & at_mask);
  assign hit_at_floor = |((set_in | set_up | set_down) & at_mask);

  // Nothing left beyond this floor also forces a stop, which keeps the car in the shaft.
  assign stop_here = (|(req_in & at_mask))
                   | (|((dir ? req_up : req_down) & at_mask))
                   | ~(dir ? any_above : any_below);

endmodule

`default_nettype wire

// File: rtl/elevator_ctrl.sv
// SCAN elevator controller: FSM, travel/door/home timers, registered outputs.
// Optional parking at floor 0 after idle timeout when HOME_RETURN_EN is defined.
`default_nettype none

module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH    = 8,
  parameter int TRAVEL_CYCLES    = 2,
  parameter int DOOR_OPEN_CYCLES = 4,
  parameter int HOME_TIMEOUT     = 16,
  localparam int LW              = $clog2(BUTTONS_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     open_btn,
  input  logic                     close_btn,
  input  logic [BUTTONS_WIDTH-1:0] btn_in,
  input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
  output logic [1:0]               engine,
  output logic [1:0]               door,
  output logic [LW-1:0]            level_display
);

  localparam int TW = cnt_width(TRAVEL_CYCLES);
  localparam int DW = cnt_width(DOOR_OPEN_CYCLES);
  localparam int HW = cnt_width(HOME_TIMEOUT);
  localparam logic [LW-1:0] TOP = LW'(BUTTONS_WIDTH - 1);

`ifdef HOME_RETURN_EN
  localparam logic HOME_EN = 1'b1;
`else
  localparam logic HOME_EN = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [LW-1:0]     floor, floor_nxt, step_floor, qfloor;
  logic              dir, dir_nxt;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic [DW-1:0]     dcnt, dcnt_nxt;
  logic [HW-1:0]     hcnt, hcnt_nxt;
  logic [1:0]        engine_nxt, door_nxt;
  logic              clr, arrive, go_up, go_down, idle_quiet, home_call;
  logic              any_above, any_below, any_at_floor, hit_at_floor, stop_here;
  logic [BUTTONS_WIDTH-1:0] set_in;

  // While arriving, the table is queried for the floor being entered so the stop lands on that edge.
  assign arrive     = ((state == ST_MOVE_UP) || (state == ST_MOVE_DOWN))
                   && (tcnt == TW'(TRAVEL_CYCLES - 1));
  assign step_floor = (state == ST_MOVE_UP) ? ((floor == TOP) ? floor : floor + 1'b1)
                                            : ((floor == '0)  ? floor : floor - 1'b1);
  assign qfloor     = arrive ? step_floor : floor;

  assign go_up   = any_above && (dir || !any_below);
  assign go_down = any_below && !go_up;

  assign idle_quiet = HOME_EN && (state == ST_IDLE) && (floor != '0)
                   && !any_above && !any_below && !any_at_floor
                   && !(|{btn_in, btn_up_out, btn_down_out});
  assign home_call  = idle_quiet && (hcnt == HW'(HOME_TIMEOUT - 1));
  assign hcnt_nxt   = (idle_quiet && !home_call) ? hcnt + HW'(1) : '0;
  assign set_in     = btn_in | {{(BUTTONS_WIDTH-1){1'b0}}, home_call};

  elevator_req_table #(
    .BUTTONS_WIDTH (BUTTONS_WIDTH),
    .LW            (LW)
  ) u_req (
    .clk          (clk),
    .reset        (reset),
    .set_in       (set_in),
    .set_up       (btn_up_out),
    .set_down     (btn_down_out),
    .clr          (clr),
    .floor        (qfloor),
    .dir          (dir),
    .any_above    (any_above),
    .any_below    (any_below),
    .any_at_floor (any_at_floor),
    .hit_at_floor (hit_at_floor),
    .stop_here    (stop_here)
  );

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    floor_nxt = floor;
    tcnt_nxt  = '0;
    dcnt_nxt  = '0;
    case (state)
      ST_IDLE: begin
        if (open_btn || any_at_floor) begin
          state_nxt = ST_DOOR_OPEN;
        end else if (go_up) begin
          state_nxt = ST_MOVE_UP;
          dir_nxt   = 1'b1;
        end else if (go_down) begin
          state_nxt = ST_MOVE_DOWN;
          dir_nxt   = 1'b0;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (arrive) begin
          floor_nxt = step_floor;
          if (stop_here) state_nxt = ST_DOOR_OPEN;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      ST_DOOR_OPEN: begin
        if (open_btn) begin
          dcnt_nxt = '0;
        end else if (close_btn || (dcnt == DW'(DOOR_OPEN_CYCLES - 1))) begin
          state_nxt = ST_DOOR_CLOSE;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      ST_DOOR_CLOSE: begin
        if (open_btn || any_at_floor || hit_at_floor) begin
          state_nxt = ST_DOOR_OPEN;
        end else if (go_up) begin
          state_nxt = ST_MOVE_UP;
          dir_nxt   = 1'b1;
        end else if (go_down) begin
          state_nxt = ST_MOVE_DOWN;
          dir_nxt   = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    clr = (state_nxt == ST_DOOR_OPEN);

    case (state_nxt)
      ST_MOVE_UP:   engine_nxt = ENGINE_UP;
      ST_MOVE_DOWN: engine_nxt = ENGINE_DOWN;
      default:      engine_nxt = ENGINE_STOP;
    endcase
    case (state_nxt)
      ST_DOOR_OPEN:  door_nxt = DOOR_OPEN;
      ST_DOOR_CLOSE: door_nxt = DOOR_CLOSING;
      default:       door_nxt = DOOR_CLOSED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      floor  <= '0;
      dir    <= 1'b1;
      tcnt   <= '0;
      dcnt   <= '0;
      hcnt   <= '0;
      engine <= ENGINE_STOP;
      door   <= DOOR_CLOSED;
    end else begin
      state  <= state_nxt;
      floor  <= floor_nxt;
      dir    <= dir_nxt;
      tcnt   <= tcnt_nxt;
      dcnt   <= dcnt_nxt;
      hcnt   <= hcnt_nxt;
      engine <= engine_nxt;
      door   <= door_nxt;
    end
  end

  assign level_display = floor;

endmodule

`default_nettype wire

// File: tb/tb_elevator_ctrl.sv
// Directed, cycle-exact checks of elevator_ctrl at default parameters.
`default_nettype none

module tb_elevator_ctrl;

  logic       clk;
  logic       reset;
  logic       open_btn, close_btn;
  logic [7:0] btn_in, btn_up_out, btn_down_out;
  logic [1:0] engine, door;
  logic [2:0] level_display;

  int checks = 0;
  int errors = 0;
  int seen_down;

  elevator_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .open_btn      (open_btn),
    .close_btn     (close_btn),
    .btn_in        (btn_in),
    .btn_up_out    (btn_up_out),
    .btn_down_out  (btn_down_out),
    .engine        (engine),
    .door          (door),
    .level_display (level_display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [1:0] e, input logic [1:0] d, input logic [2:0] l);
    check({tag, "_engine"}, {6'd0, engine}, {6'd0, e});
    check({tag, "_door"},   {6'd0, door},   {6'd0, d});
    check({tag, "_level"},  {5'd0, level_display}, {5'd0, l});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; open_btn = 1'b0; close_btn = 1'b0;
    btn_in = '0; btn_up_out = '0; btn_down_out = '0;
    cyc(2);
    outs("reset", 2'b00, 2'b00, 3'd0);

    // Cabin call to 7: latch, then move up one floor per two cycles.
    reset = 1'b1;
    btn_in = 8'h80;
    cyc(1); btn_in = '0;
    outs("t1_latched", 2'b00, 2'b00, 3'd0);
    cyc(1); outs("t1_start", 2'b01, 2'b00, 3'd0);
    cyc(2); outs("t1_f1", 2'b01, 2'b00, 3'd1);
    cyc(11); outs("t1_f6", 2'b01, 2'b00, 3'd6);
    cyc(1); outs("t1_arrive7", 2'b00, 2'b01, 3'd7);
    cyc(3); outs("t1_open_last", 2'b00, 2'b01, 3'd7);
    cyc(1); outs("t1_closing", 2'b00, 2'b10, 3'd7);
    cyc(1); outs("t1_idle", 2'b00, 2'b00, 3'd7);

    // Hall call at current floor opens without motion, then down-run to 0.
    cyc(1); btn_down_out = 8'h80;
    cyc(1); btn_down_out = '0;
    outs("t2_latched", 2'b00, 2'b00, 3'd7);
    cyc(1); outs("t2_open_here", 2'b00, 2'b01, 3'd7);
    cyc(4); outs("t2_closing", 2'b00, 2'b10, 3'd7);
    cyc(1); outs("t2_idle", 2'b00, 2'b00, 3'd7);
    btn_up_out = 8'h01;
    cyc(1); btn_up_out = '0;
    cyc(1); outs("t2_start_down", 2'b10, 2'b00, 3'd7);
    cyc(13); outs("t2_f1", 2'b10, 2'b00, 3'd1);
    cyc(1); outs("t2_arrive0", 2'b00, 2'b01, 3'd0);
    cyc(4); outs("t2_closing0", 2'b00, 2'b10, 3'd0);
    cyc(1); outs("t2_idle0", 2'b00, 2'b00, 3'd0);

    // Cabin 5 and down-call 3 together: pass 3 going up, serve 5, then 3.
    btn_in = 8'h20; btn_down_out = 8'h08;
    cyc(1); btn_in = '0; btn_down_out = '0;
    cyc(1); outs("t3_start", 2'b01, 2'b00, 3'd0);
    cyc(6); outs("t3_pass3", 2'b01, 2'b00, 3'd3);
    cyc(4); outs("t3_stop5", 2'b00, 2'b01, 3'd5);
    cyc(4); outs("t3_close5", 2'b00, 2'b10, 3'd5);
    cyc(1); outs("t3_reverse", 2'b10, 2'b00, 3'd5);
    cyc(4); outs("t3_stop3", 2'b00, 2'b01, 3'd3);
    cyc(5); outs("t3_idle3", 2'b00, 2'b00, 3'd3);
    cyc(4); outs("t3_cleared", 2'b00, 2'b00, 3'd3);

    // Door buttons: open from idle, close early, reopen while closing, open beats close.
    open_btn = 1'b1;
    cyc(1); open_btn = 1'b0;
    outs("t4_open", 2'b00, 2'b01, 3'd3);
    close_btn = 1'b1;
    cyc(1); close_btn = 1'b0;
    outs("t4_close_early", 2'b00, 2'b10, 3'd3);
    open_btn = 1'b1;
    cyc(1); open_btn = 1'b0;
    outs("t4_reopen", 2'b00, 2'b01, 3'd3);
    cyc(1); open_btn = 1'b1; close_btn = 1'b1;
    cyc(1); open_btn = 1'b0; close_btn = 1'b0;
    outs("t4_both", 2'b00, 2'b01, 3'd3);
    cyc(3); outs("t4_restart_hold", 2'b00, 2'b01, 3'd3);
    cyc(1); outs("t4_restart_close", 2'b00, 2'b10, 3'd3);
    cyc(1); outs("t4_idle", 2'b00, 2'b00, 3'd3);

    // Reset mid-travel at floor 4; door buttons held while moving are ignored.
    btn_in = 8'h80;
    cyc(1); btn_in = '0;
    cyc(1); outs("t5_start", 2'b01, 2'b00, 3'd3);
    open_btn = 1'b1; close_btn = 1'b1;
    cyc(2); outs("t5_f4", 2'b01, 2'b00, 3'd4);
    open_btn = 1'b0; close_btn = 1'b0;
    reset = 1'b0;
    #1 outs("t5_async_reset", 2'b00, 2'b00, 3'd0);
    @(negedge clk); reset = 1'b1;
    cyc(3); outs("t5_req_cleared", 2'b00, 2'b00, 3'd0);

    // Park at 7 and watch the idle period.
    btn_in = 8'h80;
    cyc(1); btn_in = '0;
    cyc(20); outs("t6_parked7", 2'b00, 2'b00, 3'd7);
    seen_down = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (engine == 2'b10) seen_down = 1;
      if (level_display == 3'd0 && door == 2'b01) break;
    end
`ifdef HOME_RETURN_EN
    check("t6_home_moved_down", 8'(seen_down), 8'd1);
    check("t6_home_level", {5'd0, level_display}, 8'd0);
    check("t6_home_door", {6'd0, door}, 8'h01);
`else
    check("t6_stay_no_motion", 8'(seen_down), 8'd0);
    check("t6_stay_level", {5'd0, level_display}, 8'd7);
    check("t6_stay_door", {6'd0, door}, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
